sf_camera_reader: RTL and testbench

//  Pixel-clock-domain capture stage directly downstream of the camera's vsync/hsync/pix_data bus.

---
 rtl/sf_camera_reader.sv | 204 ++++++++++++++++++++
 tb/tb_sf_camera_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf_camera_reader.sv
// Camera byte-stream capture: frames vsync/hsync, packs bytes into 32-bit FIFO words, reports row/byte stats.
// Optional feature macro: SF_CAMERA_READER_FRAME_COUNT_EN adds a free-running o_frame_count output.
module sf_camera_reader #(
    parameter int unsigned BYTE_ORDER = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 i_cam_clk,
    input  logic                 i_cam_rst,
    input  logic                 i_enable,
    input  logic                 i_clear_status,
    input  logic                 i_vsync,
    input  logic                 i_hsync,
    input  logic [7:0]           i_pix_data,
    input  logic                 i_wr_ready,
    output logic                 o_wr_stb,
    output logic [31:0]          o_wr_data,
    output logic                 o_frame_start,
    output logic                 o_frame_done,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_row_count,
    output logic [CNT_WIDTH-1:0] o_row_bytes,
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
    output logic [31:0]          o_frame_count,
`endif
    output logic                 o_overflow
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VLOW,
        WAIT_VHIGH,
        CAPTURE,
        ROW_END,
        FRAME_END
    } state_t;

    state_t                state, state_n;
    logic                  vs_q, hs_q, vs_d, hs_d;
    logic [7:0]            pd_q;
    logic [WORD_W-1:0]     acc, acc_n, acc_plus, word;
    logic [LANE_W-1:0]     lane, lane_n, pos;
    logic [CNT_WIDTH-1:0]  byte_cnt, byte_cnt_n, row_cnt, row_cnt_n;
    logic [CNT_WIDTH-1:0]  row_count_n, row_bytes_n;
    logic [WORD_W-1:0]     wr_data_n;
    logic                  wr_stb_n, frame_start_n, frame_done_n, busy_n, overflow_n;
    logic                  word_done, ov_set;
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
    logic [31:0]           frame_count_n;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Byte lane of the incoming byte within the word being assembled
    assign pos      = (BYTE_ORDER == 0) ? LANE_W'(2'd3 - lane) : lane;
    assign acc_plus = acc | (WORD_W'(pd_q) << {pos, 3'b000});

    always_comb begin
        state_n       = state;
        acc_n         = acc;
        lane_n        = lane;
        byte_cnt_n    = byte_cnt;
        row_cnt_n     = row_cnt;
        row_count_n   = o_row_count;
        row_bytes_n   = o_row_bytes;
        wr_stb_n      = 1'b0;
        wr_data_n     = o_wr_data;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        word_done     = 1'b0;
        word          = acc;
        ov_set        = 1'b0;

        case (state)
            IDLE: begin
                if (i_enable) state_n = WAIT_VLOW;
            end
            WAIT_VLOW: begin
                if (!vs_q) state_n = WAIT_VHIGH;
            end
            WAIT_VHIGH: begin
                if (vs_q && !vs_d) begin
                    frame_start_n = 1'b1;
                    row_cnt_n     = '0;
                    byte_cnt_n    = '0;
                    acc_n         = '0;
                    lane_n        = '0;
                    state_n       = CAPTURE;
                end else if (!i_enable) begin
                    state_n = IDLE;
                end
            end
            CAPTURE: begin
                if (hs_q) begin
                    byte_cnt_n = sat_inc(byte_cnt);
                    if (lane == LANE_W'(3)) begin
                        word_done = 1'b1;
                        word      = acc_plus;
                        acc_n     = '0;
                        lane_n    = '0;
                    end else begin
                        acc_n  = acc_plus;
                        lane_n = LANE_W'(lane + LANE_W'(1));
                    end
                end else if (hs_d) begin
                    // Partial word is strobed during the ROW_END cycle
                    word_done = (lane != '0);
                    word      = acc;
                    acc_n     = '0;
                    lane_n    = '0;
                    state_n   = ROW_END;
                end else if (!vs_q) begin
                    frame_done_n = 1'b1;
                    state_n      = FRAME_END;
                end
            end
            ROW_END: begin
                row_bytes_n = byte_cnt;
                row_cnt_n   = sat_inc(row_cnt);
                byte_cnt_n  = '0;
                if (vs_q) begin
                    state_n = CAPTURE;
                end else begin
                    frame_done_n = 1'b1;
                    state_n      = FRAME_END;
                end
            end
            FRAME_END: begin
                row_count_n = row_cnt;
                state_n     = i_enable ? WAIT_VHIGH : IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Camera cannot stall: a word with no FIFO room is dropped
        if (word_done) begin
            if (i_wr_ready) begin
                wr_stb_n  = 1'b1;
                wr_data_n = word;
            end else begin
                ov_set = 1'b1;
            end
        end

        overflow_n = ov_set | (o_overflow & ~i_clear_status);
        busy_n     = !((state_n == IDLE) || (state_n == WAIT_VLOW));
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
        frame_count_n = frame_done_n ? o_frame_count + 32'd1 : o_frame_count;
`endif
    end

    always_ff @(posedge i_cam_clk or negedge i_cam_rst) begin
        if (!i_cam_rst) begin
            state         <= IDLE;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            vs_d          <= 1'b0;
            hs_d          <= 1'b0;
            pd_q          <= '0;
            acc           <= '0;
            lane          <= '0;
            byte_cnt      <= '0;
            row_cnt       <= '0;
            o_wr_stb      <= 1'b0;
            o_wr_data     <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_busy        <= 1'b0;
            o_row_count   <= '0;
            o_row_bytes   <= '0;
            o_overflow    <= 1'b0;
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
            o_frame_count <= '0;
`endif
        end else begin
            state         <= state_n;
            vs_q          <= i_vsync;
            hs_q          <= i_hsync;
            vs_d          <= vs_q;
            hs_d          <= hs_q;
            pd_q          <= i_pix_data;
            acc           <= acc_n;
            lane          <= lane_n;
            byte_cnt      <= byte_cnt_n;
            row_cnt       <= row_cnt_n;
            o_wr_stb      <= wr_stb_n;
            o_wr_data     <= wr_data_n;
            o_frame_start <= frame_start_n;
            o_frame_done  <= frame_done_n;
            o_busy        <= busy_n;
            o_row_count   <= row_count_n;
            o_row_bytes   <= row_bytes_n;
            o_overflow    <= overflow_n;
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
            o_frame_count <= frame_count_n;
`endif
        end
    end

endmodule

// File: tb/tb_sf_camera_reader.sv
// Directed bench for sf_camera_reader: a default instance plus a BYTE_ORDER=1, CNT_WIDTH=4 instance on shared inputs.
module tb_sf_camera_reader;

    logic clk = 1'b0;
    logic rst_n, enable, clear_status, vsync, hsync, wr_ready;
    logic [7:0] pix;

    logic        stb0, fs0, fd0, busy0, ov0;
    logic [31:0] data0;
    logic [15:0] rc0, rb0;
    logic        stb1, fs1, fd1, busy1, ov1;
    logic [31:0] data1;
    logic [3:0]  rc1, rb1;
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
    logic [31:0] fc0, fc1;
`endif

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int starts = 0;
    int dones = 0;
    logic [31:0] words0[$];
    logic [31:0] words1[$];
    int times0[$];

    always #5 clk = ~clk;

    sf_camera_reader #(.BYTE_ORDER(0), .CNT_WIDTH(16)) dut0 (
        .i_cam_clk(clk), .i_cam_rst(rst_n), .i_enable(enable), .i_clear_status(clear_status),
        .i_vsync(vsync), .i_hsync(hsync), .i_pix_data(pix), .i_wr_ready(wr_ready),
        .o_wr_stb(stb0), .o_wr_data(data0), .o_frame_start(fs0), .o_frame_done(fd0),
        .o_busy(busy0), .o_row_count(rc0), .o_row_bytes(rb0),
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
        .o_frame_count(fc0),
`endif
        .o_overflow(ov0));

    sf_camera_reader #(.BYTE_ORDER(1), .CNT_WIDTH(4)) dut1 (
        .i_cam_clk(clk), .i_cam_rst(rst_n), .i_enable(enable), .i_clear_status(clear_status),
        .i_vsync(vsync), .i_hsync(hsync), .i_pix_data(pix), .i_wr_ready(wr_ready),
        .o_wr_stb(stb1), .o_wr_data(data1), .o_frame_start(fs1), .o_frame_done(fd1),
        .o_busy(busy1), .o_row_count(rc1), .o_row_bytes(rb1),
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
        .o_frame_count(fc1),
`endif
        .o_overflow(ov1));

    // Record outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (stb0) begin
            words0.push_back(data0);
            times0.push_back(cyc_cnt);
        end
        if (stb1) words1.push_back(data1);
        if (fs0) starts = starts + 1;
        if (fd0) dones = dones + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words0.delete();
        words1.delete();
        times0.delete();
        starts = 0;
        dones = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic send_frame(input int rows, input int nbytes, input bit drop,
                              input int en_row, input bit joint);
        vsync = 1'b1;
        repeat (3) cyc();
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < nbytes; b++) begin
                if (r == en_row && b == nbytes / 2) enable = 1'b1;
                hsync = 1'b1;
                pix = 8'(b);
                wr_ready = !(drop && r == 0 && b >= 9 && b <= 14);
                cyc();
            end
            wr_ready = 1'b1;
            hsync = 1'b0;
            pix = 8'h00;
            if (joint && r == rows - 1) vsync = 1'b0;
            else repeat (4) cyc();
        end
        vsync = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({stb0, data0, fs0, fd0, busy0, rc0, rb0, ov0} !== '0) begin
            fails++;
            $display("FAIL reset_outputs0: got stb=%b data=%h fs=%b fd=%b busy=%b rc=%0d rb=%0d ov=%b, expected all 0",
                     stb0, data0, fs0, fd0, busy0, rc0, rb0, ov0);
        end
        tests++;
        if ({stb1, data1, fs1, fd1, busy1, rc1, rb1, ov1} !== '0) begin
            fails++;
            $display("FAIL reset_outputs1: got nonzero outputs, expected all 0");
        end
    endtask

    task automatic test_full_frame();
        enable = 1'b1;
        repeat (4) cyc();
        clear_mon();
        send_frame(16, 32, 1'b0, -1, 1'b0);
        tests++;
        if (words0.size() != 128) begin fails++; $display("FAIL full_strobes: got %0d expected 128", words0.size()); end
        tests++;
        if (words0.size() < 128 || words0[0] !== 32'h00010203 || words0[7] !== 32'h1C1D1E1F || words0[127] !== 32'h1C1D1E1F) begin
            fails++; $display("FAIL full_words: got w0=%h w7=%h expected 00010203 1c1d1e1f",
                              words0.size() > 7 ? words0[0] : 32'hx, words0.size() > 7 ? words0[7] : 32'hx);
        end
        tests++;
        if (rb0 !== 16'd32 || rc0 !== 16'd16) begin fails++; $display("FAIL full_stats: got rb=%0d rc=%0d expected 32 16", rb0, rc0); end
        tests++;
        if (starts != 1 || dones != 1) begin fails++; $display("FAIL full_pulses: got start=%0d done=%0d expected 1 1", starts, dones); end
        tests++;
        if (rb1 !== 4'd15 || rc1 !== 4'd15) begin fails++; $display("FAIL saturate: got rb=%0d rc=%0d expected 15 15", rb1, rc1); end
        tests++;
        if (words1.size() < 1 || words1[0] !== 32'h03020100) begin
            fails++; $display("FAIL byte_order1: got %h expected 03020100", words1.size() > 0 ? words1[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        tests++;
        if (times0.size() < 2 || times0[1] - times0[0] != 4) begin
            fails++; $display("FAIL back_to_back_gap: got %0d expected 4", times0.size() > 1 ? times0[1] - times0[0] : -1);
        end
    endtask

    task automatic test_partial_row();
        clear_mon();
        send_frame(1, 6, 1'b0, -1, 1'b0);
        tests++;
        if (words0.size() != 2 || words0[0] !== 32'h00010203 || words0[1] !== 32'h04050000) begin
            fails++; $display("FAIL partial_words0: got n=%0d w1=%h expected 2 04050000",
                              words0.size(), words0.size() > 1 ? words0[1] : 32'hx);
        end
        tests++;
        if (words1.size() != 2 || words1[1] !== 32'h00000504) begin
            fails++; $display("FAIL partial_words1: got n=%0d expected 2 with w1=00000504", words1.size());
        end
        tests++;
        if (times0.size() != 2 || times0[1] - times0[0] != 3) begin
            fails++; $display("FAIL partial_timing: got gap %0d expected 3", times0.size() > 1 ? times0[1] - times0[0] : -1);
        end
        tests++;
        if (rb0 !== 16'd6 || rc0 !== 16'd1) begin fails++; $display("FAIL partial_stats: got rb=%0d rc=%0d expected 6 1", rb0, rc0); end
    endtask

    task automatic test_joint_fall();
        clear_mon();
        send_frame(3, 8, 1'b0, -1, 1'b1);
        tests++;
        if (rc0 !== 16'd3 || rb0 !== 16'd8 || words0.size() != 6 || dones != 1) begin
            fails++; $display("FAIL joint_fall: got rc=%0d rb=%0d n=%0d done=%0d expected 3 8 6 1", rc0, rb0, words0.size(), dones);
        end
    endtask

    task automatic test_overflow();
        clear_mon();
        send_frame(16, 32, 1'b1, -1, 1'b0);
        tests++;
        if (words0.size() != 127) begin fails++; $display("FAIL ovf_strobes: got %0d expected 127", words0.size()); end
        tests++;
        if (words0.size() < 3 || words0[2] !== 32'h0C0D0E0F) begin
            fails++; $display("FAIL ovf_word2: got %h expected 0c0d0e0f", words0.size() > 2 ? words0[2] : 32'hx);
        end
        tests++;
        if (ov0 !== 1'b1 || ov1 !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b %b expected 1 1", ov0, ov1); end
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        cyc();
        tests++;
        if (ov0 !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", ov0); end
    endtask

    task automatic test_late_enable();
        enable = 1'b0;
        repeat (3) cyc();
        clear_mon();
        send_frame(8, 32, 1'b0, 5, 1'b0);
        tests++;
        if (words0.size() != 0 || starts != 0) begin
            fails++; $display("FAIL late_enable_idle: got %0d strobes %0d starts expected 0 0", words0.size(), starts);
        end
        send_frame(16, 32, 1'b0, -1, 1'b0);
        tests++;
        if (words0.size() != 128 || starts != 1) begin
            fails++; $display("FAIL late_enable_next: got %0d strobes %0d starts expected 128 1", words0.size(), starts);
        end
    endtask

    task automatic test_reset_mid_row();
        clear_mon();
        vsync = 1'b1;
        repeat (3) cyc();
        for (int b = 0; b < 10; b++) begin
            hsync = 1'b1;
            pix = 8'(b);
            cyc();
        end
        tests++;
        if (words0.size() != 2) begin fails++; $display("FAIL prereset_words: got %0d expected 2", words0.size()); end
        rst_n = 1'b0;
        #2;
        tests++;
        if ({stb0, data0, fs0, fd0, busy0, rc0, rb0, ov0} !== '0) begin
            fails++; $display("FAIL reset_immediate: got busy=%b rc=%0d rb=%0d data=%h expected all 0", busy0, rc0, rb0, data0);
        end
        clear_mon();
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int b = 10; b < 32; b++) begin
            pix = 8'(b);
            cyc();
        end
        hsync = 1'b0;
        repeat (4) cyc();
        vsync = 1'b0;
        repeat (6) cyc();
        tests++;
        if (words0.size() != 0) begin fails++; $display("FAIL reset_no_partial: got %0d strobes expected 0", words0.size()); end
        send_frame(16, 32, 1'b0, -1, 1'b0);
        tests++;
        if (words0.size() != 128 || words0[0] !== 32'h00010203 || words0[127] !== 32'h1C1D1E1F || rc0 !== 16'd16) begin
            fails++; $display("FAIL reset_recover: got n=%0d rc=%0d expected 128 16", words0.size(), rc0);
        end
    endtask

`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
    task automatic test_frame_count();
        do_reset();
        repeat (3) cyc();
        for (int f = 0; f < 3; f++) send_frame(2, 8, 1'b0, -1, 1'b0);
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        tests++;
        if (fc0 !== 32'd3 || fc1 !== 32'd3) begin fails++; $display("FAIL frame_count: got %0d %0d expected 3 3", fc0, fc1); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        clear_status = 1'b0;
        vsync = 1'b0;
        hsync = 1'b0;
        pix = 8'h00;
        wr_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_partial_row();
        test_joint_fall();
        test_overflow();
        test_late_enable();
        test_reset_mid_row();
`ifdef SF_CAMERA_READER_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
